// File: rtl/img_scale_ctrl.sv
// ============================================================================
//  Module      : img_scale_ctrl
//  Description : Pixel-replication zoom sequencer. It reads each source pixel
//                once from the image ROM, then writes it FxF times into the
//                framebuffer. Optional abort port under SCALE_ABORT_EN.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module img_scale_ctrl #(
   parameter int SRC_W   = 160,
   parameter int SRC_H   = 120,
   parameter int ROM_AW  = 19,
   parameter int FB_AW   = 19,
   parameter int ROM_LAT = 1,
   parameter int PIX_W   = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [1:0]        factor_sel,
   output logic              busy,
   output logic              done,
   output logic              rom_en,
   output logic [ROM_AW-1:0] rom_addr,
   input  logic [PIX_W-1:0]  rom_data,
   output logic              fb_wr_valid,
   input  logic              fb_wr_ready,
   output logic [FB_AW-1:0]  fb_addr,
   output logic [PIX_W-1:0]  fb_data
`ifdef SCALE_ABORT_EN
   ,
   input  logic              abort
`endif
);

   localparam int C_COL_W = (SRC_W > 1) ? $clog2(SRC_W) : 1;
   localparam int C_ROW_W = (SRC_H > 1) ? $clog2(SRC_H) : 1;
   localparam int C_LAT_W = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_READ  = 3'd1,
      S_WAIT  = 3'd2,
      S_WRITE = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t               state_q, state_d;
   logic [C_COL_W-1:0]   col_q, col_d;
   logic [C_ROW_W-1:0]   row_q, row_d;
   logic [1:0]           di_q, di_d;
   logic [1:0]           dj_q, dj_d;
   logic [C_LAT_W-1:0]   lat_q, lat_d;
   logic [1:0]           fs_q, fs_d;      // log2 of the zoom factor
   logic [PIX_W-1:0]     pix_q, pix_d;
`ifdef SCALE_ABORT_EN
   logic                 abort_pend_q, abort_pend_d;
`endif

   logic [1:0]           w_fmax;
   logic [FB_AW-1:0]     w_fb_row;
   logic [FB_AW-1:0]     w_fb_col;
   logic [FB_AW-1:0]     w_fb_stride;

   always_comb begin
      case (fs_q)
         2'd0:    w_fmax = 2'd0;
         2'd1:    w_fmax = 2'd1;
         default: w_fmax = 2'd3;
      endcase
   end

   // Multiplication by F reduces to a left shift by fs_q.
   assign w_fb_row    = (FB_AW'(row_q) << fs_q) + FB_AW'(di_q);
   assign w_fb_col    = (FB_AW'(col_q) << fs_q) + FB_AW'(dj_q);
   assign w_fb_stride = FB_AW'(SRC_W) << fs_q;

   assign fb_addr     = w_fb_row * w_fb_stride + w_fb_col;
   assign rom_addr    = ROM_AW'(row_q) * ROM_AW'(SRC_W) + ROM_AW'(col_q);
   assign fb_data     = pix_q;
   assign busy        = (state_q != S_IDLE);
   assign done        = (state_q == S_DONE);
   assign rom_en      = (state_q == S_READ);
   assign fb_wr_valid = (state_q == S_WRITE);

   always_comb begin
      state_d = state_q;
      col_d   = col_q;
      row_d   = row_q;
      di_d    = di_q;
      dj_d    = dj_q;
      lat_d   = lat_q;
      fs_d    = fs_q;
      pix_d   = pix_q;
`ifdef SCALE_ABORT_EN
      abort_pend_d = (state_q == S_WRITE) ? abort_pend_q : 1'b0;
`endif

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_READ;
               case (factor_sel)
                  2'b00:   fs_d = 2'd0;
                  2'b01:   fs_d = 2'd1;
                  default: fs_d = 2'd2;
               endcase
            end
         end
         S_READ: begin
            state_d = S_WAIT;
            lat_d   = '0;
         end
         S_WAIT: begin
            if (lat_q == C_LAT_W'(ROM_LAT - 1)) begin
               pix_d   = rom_data;
               lat_d   = '0;
               state_d = S_WRITE;
            end else begin
               lat_d = lat_q + 1'b1;
            end
         end
         S_WRITE: begin
            if (fb_wr_ready) begin
               if (dj_q != w_fmax) begin
                  dj_d = dj_q + 2'd1;
               end else begin
                  dj_d = 2'd0;
                  if (di_q != w_fmax) begin
                     di_d = di_q + 2'd1;
                  end else begin
                     di_d = 2'd0;
                     if (col_q != C_COL_W'(SRC_W - 1)) begin
                        col_d   = col_q + 1'b1;
                        state_d = S_READ;
                     end else begin
                        col_d = '0;
                        if (row_q != C_ROW_W'(SRC_H - 1)) begin
                           row_d   = row_q + 1'b1;
                           state_d = S_READ;
                        end else begin
                           row_d   = '0;
                           state_d = S_DONE;
                        end
                     end
                  end
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

`ifdef SCALE_ABORT_EN
      // An abort seen mid-beat is remembered until that beat is accepted.
      if (((state_q == S_READ) || (state_q == S_WAIT)) && abort) begin
         state_d = S_IDLE;
         col_d   = '0;
         row_d   = '0;
         di_d    = 2'd0;
         dj_d    = 2'd0;
         lat_d   = '0;
      end else if ((state_q == S_WRITE) && (abort || abort_pend_q)) begin
         if (fb_wr_ready) begin
            state_d      = S_IDLE;
            col_d        = '0;
            row_d        = '0;
            di_d         = 2'd0;
            dj_d         = 2'd0;
            lat_d        = '0;
            abort_pend_d = 1'b0;
         end else begin
            abort_pend_d = 1'b1;
         end
      end
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         col_q   <= '0;
         row_q   <= '0;
         di_q    <= 2'd0;
         dj_q    <= 2'd0;
         lat_q   <= '0;
         fs_q    <= 2'd0;
         pix_q   <= '0;
      end else begin
         state_q <= state_d;
         col_q   <= col_d;
         row_q   <= row_d;
         di_q    <= di_d;
         dj_q    <= dj_d;
         lat_q   <= lat_d;
         fs_q    <= fs_d;
         pix_q   <= pix_d;
      end
   end

`ifdef SCALE_ABORT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         abort_pend_q <= 1'b0;
      end else begin
         abort_pend_q <= abort_pend_d;
      end
   end
`endif

endmodule

`default_nettype wire

// File: tb/tb_img_scale_ctrl.sv
// ============================================================================
//  Module      : tb_img_scale_ctrl
//  Description : Self-checking bench for img_scale_ctrl on a 2x2 source image.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_img_scale_ctrl;

   localparam int SRC_W   = 2;
   localparam int SRC_H   = 2;
   localparam int ROM_AW  = 19;
   localparam int FB_AW   = 19;
   localparam int ROM_LAT = 1;
   localparam int PIX_W   = 8;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic [1:0]        factor_sel;
   logic              busy;
   logic              done;
   logic              rom_en;
   logic [ROM_AW-1:0] rom_addr;
   logic [PIX_W-1:0]  rom_data;
   logic              fb_wr_valid;
   logic              fb_wr_ready;
   logic [FB_AW-1:0]  fb_addr;
   logic [PIX_W-1:0]  fb_data;
`ifdef SCALE_ABORT_EN
   logic              abort;
`endif

   img_scale_ctrl #(
      .SRC_W(SRC_W), .SRC_H(SRC_H), .ROM_AW(ROM_AW), .FB_AW(FB_AW),
      .ROM_LAT(ROM_LAT), .PIX_W(PIX_W)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .factor_sel(factor_sel),
      .busy(busy), .done(done), .rom_en(rom_en), .rom_addr(rom_addr),
      .rom_data(rom_data), .fb_wr_valid(fb_wr_valid), .fb_wr_ready(fb_wr_ready),
      .fb_addr(fb_addr), .fb_data(fb_data)
`ifdef SCALE_ABORT_EN
      , .abort(abort)
`endif
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int c0       = 0;
   int done_cnt = 0;
   bit tog_en   = 1'b0;

   logic [PIX_W-1:0] rom_mem [4];
   int exp_wa[$];
   int exp_wd[$];
   int exp_ra[$];
   int log_wa[$];
   int log_wd[$];

   always @(posedge clk) cyc <= cyc + 1;

   // One-cycle-latency ROM.
   always @(posedge clk) if (rom_en) rom_data <= rom_mem[rom_addr[1:0]];

   // Sole driver of fb_wr_ready: held high, or toggled every cycle.
   initial begin
      fb_wr_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         fb_wr_ready = tog_en ? ~fb_wr_ready : 1'b1;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic flag(input string nm);
      checks++;
      failures++;
      $display("FAIL %s: event occurred that should not", nm);
   endtask

   // Compare process: every write beat must present the next expected pair,
   // held steady while stalled; every ROM read must hit the next source pixel.
   always @(negedge clk) begin
      if (!rst) begin
         if (fb_wr_valid) begin
            chk("no_rom_in_write", {31'd0, rom_en}, 32'd0);
            if (exp_wa.size() == 0) begin
               flag("extra_write");
            end else begin
               chk("wr_addr", fb_addr, exp_wa[0]);
               chk("wr_data", fb_data, exp_wd[0]);
               if (fb_wr_ready) begin
                  log_wa.push_back(int'(fb_addr));
                  log_wd.push_back(int'(fb_data));
                  void'(exp_wa.pop_front());
                  void'(exp_wd.pop_front());
               end
            end
         end
         if (rom_en) begin
            if (exp_ra.size() == 0) flag("extra_rom_read");
            else chk("rom_addr", rom_addr, exp_ra.pop_front());
         end
         if (done) done_cnt++;
      end
   end

   task automatic flush();
      exp_wa.delete(); exp_wd.delete(); exp_ra.delete();
      log_wa.delete(); log_wd.delete();
      done_cnt = 0;
   endtask

   // Reference: scan the source, replicating each pixel over an FxF block.
   task automatic build(input logic [1:0] sel);
      int f;
      f = (sel == 2'b00) ? 1 : (sel == 2'b01) ? 2 : 4;
      flush();
      for (int l = 0; l < SRC_H; l++)
         for (int c = 0; c < SRC_W; c++) begin
            exp_ra.push_back(l * SRC_W + c);
            for (int di = 0; di < f; di++)
               for (int dj = 0; dj < f; dj++) begin
                  exp_wa.push_back((l * f + di) * (SRC_W * f) + c * f + dj);
                  exp_wd.push_back(int'(rom_mem[l * SRC_W + c]));
               end
         end
   endtask

   task automatic start_frame(input logic [1:0] sel);
      build(sel);
      @(posedge clk);
      #1;
      start      = 1'b1;
      factor_sel = sel;
      @(posedge clk);
      #1;
      start      = 1'b0;
      factor_sel = sel ^ 2'b01;
      c0         = cyc - 1;
   endtask

   task automatic wait_done(input int exp_cyc, input bit poke);
      bit seen;
      int dc;
      seen = 1'b0;
      dc   = 0;
      for (int i = 0; i < 3000 && !seen; i++) begin
         @(negedge clk);
         if (done) begin
            seen = 1'b1;
            dc   = cyc - c0;
         end
      end
      if (!seen) begin
         $display("FAIL done_timeout: got no done expected done within 3000 cycles");
         checks++;
         failures++;
      end else begin
         if (exp_cyc >= 0) chk("done_cycle", dc, exp_cyc);
         chk("busy_in_done", {31'd0, busy}, 32'd1);
         if (poke) start = 1'b1;
         @(posedge clk);
         #1;
         start = 1'b0;
         @(negedge clk);
         chk("busy_after_done", {31'd0, busy}, 32'd0);
         chk("done_one_cycle", {31'd0, done}, 32'd0);
         if (poke) begin
            @(negedge clk);
            chk("start_in_done_ignored", {31'd0, busy}, 32'd0);
         end
         chk("writes_left", exp_wa.size(), 32'd0);
         chk("reads_left", exp_ra.size(), 32'd0);
         chk("done_pulses", done_cnt, 32'd1);
      end
   endtask

   task automatic chk_reset_outputs();
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_rom_en", {31'd0, rom_en}, 32'd0);
      chk("rst_fb_valid", {31'd0, fb_wr_valid}, 32'd0);
      chk("rst_rom_addr", rom_addr, 32'd0);
      chk("rst_fb_addr", fb_addr, 32'd0);
      chk("rst_fb_data", fb_data, 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int lit2 [16];
      int lit4 [16];
      lit2 = '{0, 1, 4, 5, 2, 3, 6, 7, 8, 9, 12, 13, 10, 11, 14, 15};
      lit4 = '{0, 1, 2, 3, 8, 9, 10, 11, 16, 17, 18, 19, 24, 25, 26, 27};
      rom_mem[0] = 8'hA1;
      rom_mem[1] = 8'hB2;
      rom_mem[2] = 8'hC3;
      rom_mem[3] = 8'hD4;
      rst        = 1'b1;
      start      = 1'b0;
      factor_sel = 2'b00;
`ifdef SCALE_ABORT_EN
      abort      = 1'b0;
`endif
      repeat (3) @(posedge clk);
      #1;
      chk_reset_outputs();
      rst = 1'b0;

      // x2, ready held high
      start_frame(2'b01);
      wait_done(25, 1'b0);
      chk("x2_count", log_wa.size(), 32'd16);
      for (int i = 0; i < 16; i++)
         if (i < log_wa.size()) begin
            chk("x2_lit_addr", log_wa[i], lit2[i]);
            chk("x2_lit_data", log_wd[i], 32'hA1 + (i / 4) * 32'h11);
         end

      // x1
      start_frame(2'b00);
      wait_done(13, 1'b0);
      chk("x1_count", log_wa.size(), 32'd4);
      for (int i = 0; i < 4; i++)
         if (i < log_wa.size()) begin
            chk("x1_lit_addr", log_wa[i], i);
            chk("x1_lit_data", log_wd[i], 32'hA1 + i * 32'h11);
         end

      // x4, then clamped code 11
      for (int s = 2; s < 4; s++) begin
         start_frame(2'(s));
         wait_done(73, 1'b0);
         chk("x4_count", log_wa.size(), 32'd64);
         for (int i = 0; i < 16; i++)
            if (i < log_wa.size()) begin
               chk("x4_lit_addr", log_wa[i], lit4[i]);
               chk("x4_lit_data", log_wd[i], 32'hA1);
            end
      end

      // x2 with ready toggling every cycle
      tog_en = 1'b1;
      start_frame(2'b01);
      wait_done(-1, 1'b0);
      tog_en = 1'b0;
      chk("tog_count", log_wa.size(), 32'd16);
      for (int i = 0; i < 16; i++)
         if (i < log_wa.size()) chk("tog_lit_addr", log_wa[i], lit2[i]);
      repeat (2) @(posedge clk);

      // start pulsed at cycle 3 and during the done cycle
      start_frame(2'b01);
      @(posedge clk);
      @(posedge clk);
      #1;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_done(25, 1'b1);
      start_frame(2'b01);
      wait_done(25, 1'b0);

      // rst asserted during the second write beat
      start_frame(2'b01);
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("in_2nd_beat", {31'd0, fb_wr_valid}, 32'd1);
      rst = 1'b1;
      #1;
      chk_reset_outputs();
      flush();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rst_hold_rom_en", {31'd0, rom_en}, 32'd0);
         chk("rst_hold_valid", {31'd0, fb_wr_valid}, 32'd0);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_idle", {31'd0, busy}, 32'd0);
      start_frame(2'b01);
      wait_done(25, 1'b0);

`ifdef SCALE_ABORT_EN
      // abort during WAIT of the first pixel
      start_frame(2'b01);
      @(posedge clk);
      #1;
      abort = 1'b1;
      @(posedge clk);
      #1;
      abort = 1'b0;
      @(negedge clk);
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_no_write", log_wa.size(), 32'd0);
      repeat (2) @(negedge clk);
      chk("abort_no_done", done_cnt, 32'd0);
      flush();
      start_frame(2'b01);
      wait_done(25, 1'b0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
